// File: rtl/brnch_pred_resolve.sv
// Branch resolution for the four conditional types plus a PC-indexed table of
// saturating prediction counters, a registered resolve/mispredict result and perf counters.
module brnch_pred_resolve #(
    parameter int PC_W   = 16,
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   lu_pc,
    output logic              lu_pred,
    input  logic              rs_valid,
    input  logic [PC_W-1:0]   rs_pc,
    input  logic              rs_zero,
    input  logic              rs_neg,
    input  logic [1:0]        rs_typ,
    input  logic              rs_pred,
    output logic              res_valid,
    output logic              res_taken,
    output logic              res_mispred,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] stat_br,
    output logic [STAT_W-1:0] stat_mp
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_RST = {1'b0, {(CTR_W-1){1'b1}}};

    logic [CTR_W-1:0]  tbl_q [ENTRIES];
    logic [IDX_W-1:0]  lu_idx;
    logic [IDX_W-1:0]  rs_idx;
    logic              taken_d;
    logic              mispred_d;
    logic              res_valid_q;
    logic              res_taken_q;
    logic              res_mispred_q;
    logic [STAT_W-1:0] stat_br_q;
    logic [STAT_W-1:0] stat_br_d;
    logic [STAT_W-1:0] stat_mp_q;
    logic [STAT_W-1:0] stat_mp_d;
    logic              unused_pc_bits;

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
        if (up)
            return (c == '1) ? c : c + CTR_W'(1);
        else
            return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
        return (s == '1) ? s : s + STAT_W'(1);
    endfunction

    // Instructions are halfword aligned, so bit 0 never selects an entry.
    assign lu_idx = lu_pc[IDX_W:1];
    assign rs_idx = rs_pc[IDX_W:1];
    assign unused_pc_bits = ^{lu_pc[0], lu_pc[PC_W-1:IDX_W+1], rs_pc[0], rs_pc[PC_W-1:IDX_W+1]};

    // No bypass: the lookup always sees the table as it was before this edge.
    assign lu_pred = tbl_q[lu_idx][CTR_W-1];

    always_comb begin
        taken_d   = 1'b0;
        case (rs_typ)
            2'b00:   taken_d = rs_zero;
            2'b01:   taken_d = ~rs_zero;
            2'b10:   taken_d = rs_neg;
            default: taken_d = rs_zero | ~rs_neg;
        endcase
        mispred_d = rs_valid & (taken_d ^ rs_pred);

        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (clr_stats) begin
            stat_br_d = '0;
            stat_mp_d = '0;
        end else begin
            if (rs_valid)  stat_br_d = stat_inc(stat_br_q);
            if (mispred_d) stat_mp_d = stat_inc(stat_mp_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= CTR_RST;
            res_valid_q   <= 1'b0;
            res_taken_q   <= 1'b0;
            res_mispred_q <= 1'b0;
            stat_br_q     <= '0;
            stat_mp_q     <= '0;
        end else begin
            if (rs_valid) tbl_q[rs_idx] <= ctr_step(tbl_q[rs_idx], taken_d);
            res_valid_q   <= rs_valid;
            res_taken_q   <= rs_valid & taken_d;
            res_mispred_q <= mispred_d;
            stat_br_q     <= stat_br_d;
            stat_mp_q     <= stat_mp_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_taken   = res_taken_q;
    assign res_mispred = res_mispred_q;
    assign stat_br     = stat_br_q;
    assign stat_mp     = stat_mp_q;

endmodule
